// File: rtl/pe_group_dispatcher_pkg.sv
// Shared types and width helpers for the PE group dispatcher and its counters.
package pe_group_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2
    } passState_t;

    // Pointer width for a 0..n-1 counter, never narrower than one bit.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_group_dispatcher_counter.sv
// Wrapping 0..MAX-1 pointer; wrap flags the enabled step out of the last slot.
module pe_wrap_counter
    import pe_group_pkg::*;
#(
    parameter  int MAX = 4,
    localparam int CW  = ptrWidth(MAX)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    assign wrap = en && (count == CW'(MAX - 1));

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pe_group_dispatcher.sv
// Steers kernel/image/psum streams onto the edge PEs of a systolic group,
// sequences multi-block accumulation and drains the row accumulators in order.
module pe_group_dispatcher
    import pe_group_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int K_GROUP    = 4,
    parameter  int O_GROUP    = 4,
    parameter  int MAX_BLOCKS = 16,
    localparam int I_GROUP    = K_GROUP + O_GROUP - 1,
    localparam int KW         = ptrWidth(K_GROUP),
    localparam int IW         = ptrWidth(I_GROUP),
    localparam int OW         = ptrWidth(O_GROUP),
    localparam int BW         = ptrWidth(MAX_BLOCKS + 1)
) (
    input  logic                          clk,
    input  logic                          aclr,
    input  logic [BW-1:0]                 cfg_blocks,
    input  logic                          cfg_psum_ld,
    input  logic                          k_in_valid,
    output logic                          k_in_rdy,
    output logic [K_GROUP-1:0]            k_edge_valid,
    input  logic [K_GROUP-1:0]            k_edge_rdy,
    input  logic                          i_in_valid,
    output logic                          i_in_rdy,
    output logic [I_GROUP-1:0]            i_edge_valid,
    input  logic [I_GROUP-1:0]            i_edge_rdy,
    input  logic                          o_in_valid,
    output logic                          o_in_rdy,
    input  logic [DATA_WIDTH-1:0]         o_in_data,
    output logic [O_GROUP-1:0]            o_edge_valid,
    output logic [DATA_WIDTH-1:0]         o_edge_data,
    input  logic [O_GROUP-1:0]            o_edge_rdy,
    input  logic [O_GROUP-1:0]            acc_valid,
    input  logic [O_GROUP*DATA_WIDTH-1:0] acc_data,
    output logic [O_GROUP-1:0]            acc_rdy,
    output logic                          out_valid,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy,
    output logic                          pass_done
);

    logic [KW-1:0] kp;
    logic [IW-1:0] ip;
    logic [OW-1:0] op;
    logic [OW-1:0] rp;
    logic          kWrap, iWrap, opWrap, rpWrap;
    logic          kFire, iFire, oFire, rFire;

    passState_t    state, stateNext;
    logic [BW-1:0] ob, obNext, blocksQ, cfgEff, curBlocks;
    logic          psumLdQ, curPsumLd, startBeat, extPhase, injValid;
    logic          wrapPend, passDoneQ, finish;

    assign kFire = k_in_valid && k_edge_rdy[kp];
    assign iFire = i_in_valid && i_edge_rdy[ip];
    assign oFire = injValid && o_edge_rdy[op];
    assign rFire = acc_valid[rp] && out_rdy;

    pe_wrap_counter #(.MAX(K_GROUP)) kCnt (.clk(clk), .aclr(aclr), .en(kFire), .count(kp), .wrap(kWrap));
    pe_wrap_counter #(.MAX(I_GROUP)) iCnt (.clk(clk), .aclr(aclr), .en(iFire), .count(ip), .wrap(iWrap));
    pe_wrap_counter #(.MAX(O_GROUP)) oCnt (.clk(clk), .aclr(aclr), .en(oFire), .count(op), .wrap(opWrap));
    pe_wrap_counter #(.MAX(O_GROUP)) rCnt (.clk(clk), .aclr(aclr), .en(rFire), .count(rp), .wrap(rpWrap));

    assign k_in_rdy = k_edge_rdy[kp];
    assign i_in_rdy = i_edge_rdy[ip];

    genvar gi;
    generate
        for (gi = 0; gi < K_GROUP; gi++) begin : gKEdge
            assign k_edge_valid[gi] = k_in_valid && (kp == KW'(gi));
        end
        for (gi = 0; gi < I_GROUP; gi++) begin : gIEdge
            assign i_edge_valid[gi] = i_in_valid && (ip == IW'(gi));
        end
        for (gi = 0; gi < O_GROUP; gi++) begin : gOEdge
            assign o_edge_valid[gi] = injValid && (op == OW'(gi));
            assign acc_rdy[gi]      = out_rdy && (rp == OW'(gi));
        end
    endgenerate

    assign out_valid = acc_valid[rp];
    assign out_data  = acc_data[rp*DATA_WIDTH +: DATA_WIDTH];

    // Until the first psum of a pass is taken, the live config drives injection.
    always_comb begin
        cfgEff = cfg_blocks;
        if (cfg_blocks == '0) begin
            cfgEff = BW'(1);
        end else if (cfg_blocks > BW'(MAX_BLOCKS)) begin
            cfgEff = BW'(MAX_BLOCKS);
        end
        startBeat = (state == LOAD) && (op == '0);
        curBlocks = startBeat ? cfgEff : blocksQ;
        curPsumLd = startBeat ? cfg_psum_ld : psumLdQ;
        extPhase  = (state == LOAD) && curPsumLd;

        injValid = 1'b0;
        case (state)
            LOAD:    injValid = curPsumLd ? o_in_valid : 1'b1;
            ACCUM:   injValid = 1'b1;
            default: injValid = 1'b0;
        endcase

        o_in_rdy    = extPhase ? o_edge_rdy[op] : 1'b0;
        o_edge_data = extPhase ? o_in_data : '0;

        finish    = (state == WAIT) && (rpWrap || wrapPend);
        stateNext = state;
        obNext    = ob;
        if (finish) begin
            stateNext = LOAD;
            obNext    = '0;
        end else if (opWrap) begin
            obNext    = ob + 1'b1;
            stateNext = ((ob + 1'b1) == curBlocks) ? WAIT : ACCUM;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state     <= LOAD;
            ob        <= '0;
            blocksQ   <= BW'(1);
            psumLdQ   <= 1'b1;
            wrapPend  <= 1'b0;
            passDoneQ <= 1'b0;
        end else begin
            state     <= stateNext;
            ob        <= obNext;
            passDoneQ <= finish;
            if (startBeat && oFire) begin
                blocksQ <= cfgEff;
                psumLdQ <= cfg_psum_ld;
            end
            // A drain wrap that lands before WAIT is remembered until WAIT is reached.
            if (finish) begin
                wrapPend <= 1'b0;
            end else if (rpWrap) begin
                wrapPend <= 1'b1;
            end
        end
    end

    assign pass_done = passDoneQ;
    assign busy      = (state != LOAD) || (kp != '0) || (ip != '0) || (op != '0) || (rp != '0);

endmodule

// File: tb/tb_pe_group_dispatcher.sv
// Directed bench for pe_group_dispatcher with K_GROUP=4, O_GROUP=4, DATA_WIDTH=32.
module tb_pe_group_dispatcher;

    logic        clk;
    logic        aclr;
    logic [4:0]  cfg_blocks;
    logic        cfg_psum_ld;
    logic        k_in_valid, k_in_rdy;
    logic [3:0]  k_edge_valid, k_edge_rdy;
    logic        i_in_valid, i_in_rdy;
    logic [6:0]  i_edge_valid, i_edge_rdy;
    logic        o_in_valid, o_in_rdy;
    logic [31:0] o_in_data;
    logic [3:0]  o_edge_valid;
    logic [31:0] o_edge_data;
    logic [3:0]  o_edge_rdy;
    logic [3:0]  acc_valid;
    logic [127:0] acc_data;
    logic [3:0]  acc_rdy;
    logic        out_valid, out_rdy;
    logic [31:0] out_data;
    logic        busy, pass_done;

    int passCnt = 0;
    int totalCnt = 0;

    pe_group_dispatcher #(.DATA_WIDTH(32), .K_GROUP(4), .O_GROUP(4), .MAX_BLOCKS(16)) dut (
        .clk(clk), .aclr(aclr), .cfg_blocks(cfg_blocks), .cfg_psum_ld(cfg_psum_ld),
        .k_in_valid(k_in_valid), .k_in_rdy(k_in_rdy), .k_edge_valid(k_edge_valid), .k_edge_rdy(k_edge_rdy),
        .i_in_valid(i_in_valid), .i_in_rdy(i_in_rdy), .i_edge_valid(i_edge_valid), .i_edge_rdy(i_edge_rdy),
        .o_in_valid(o_in_valid), .o_in_rdy(o_in_rdy), .o_in_data(o_in_data),
        .o_edge_valid(o_edge_valid), .o_edge_data(o_edge_data), .o_edge_rdy(o_edge_rdy),
        .acc_valid(acc_valid), .acc_data(acc_data), .acc_rdy(acc_rdy),
        .out_valid(out_valid), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy), .pass_done(pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("reset: hold aclr low");
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy_init got %b want 0", busy); else passCnt++;
        totalCnt++; if (pass_done !== 1'b0) $display("FAIL reset_pd_init got %b want 0", pass_done); else passCnt++;
        aclr = 1'b1;
        step();
        // move some pointers, then drop reset mid-pass
        k_in_valid = 1'b1; o_in_valid = 1'b1; cfg_blocks = 5'd2; o_in_data = 32'd7;
        step(); step();
        k_in_valid = 1'b0; o_in_valid = 1'b0;
        #1;
        totalCnt++; if (busy !== 1'b1) $display("FAIL reset_busy_mid got %b want 1", busy); else passCnt++;
        aclr = 1'b0;
        k_in_valid = 1'b1;
        #1;
        $display("reset: asserted mid-pass");
        totalCnt++; if (k_edge_valid !== 4'b0001) $display("FAIL reset_kedge got %b want 0001", k_edge_valid); else passCnt++;
        totalCnt++; if (o_edge_valid !== 4'b0000) $display("FAIL reset_oedge got %b want 0000", o_edge_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passCnt++;
        totalCnt++; if (acc_rdy !== 4'b0000) $display("FAIL reset_accrdy got %b want 0000", acc_rdy); else passCnt++;
        step();
        totalCnt++; if (pass_done !== 1'b0) $display("FAIL reset_pd got %b want 0", pass_done); else passCnt++;
        k_in_valid = 1'b0;
        aclr = 1'b1;
        step();
    endtask

    task automatic test_kernel();
        logic [3:0] exp;
        k_in_valid = 1'b1;
        for (int b = 0; b < 12; b++) begin
            exp = 4'b0001 << (b % 4);
            #1;
            $display("kernel beat %0d: edge=%b rdy=%b", b, k_edge_valid, k_in_rdy);
            totalCnt++; if (k_edge_valid !== exp) $display("FAIL kedge beat %0d got %b want %b", b, k_edge_valid, exp); else passCnt++;
            totalCnt++; if (k_in_rdy !== 1'b1) $display("FAIL krdy beat %0d got %b want 1", b, k_in_rdy); else passCnt++;
            step();
        end
        k_in_valid = 1'b0;
        #1;
        totalCnt++; if (k_edge_valid !== 4'b0000) $display("FAIL kedge_idle got %b want 0000", k_edge_valid); else passCnt++;
    endtask

    task automatic test_image();
        int ipSeq [9] = '{0, 1, 2, 3, 4, 4, 4, 5, 6};
        logic [6:0] exp;
        logic expRdy;
        i_in_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            i_edge_rdy = (c == 4 || c == 5) ? 7'b1101111 : 7'b1111111;
            exp = 7'b0000001 << ipSeq[c];
            expRdy = !(c == 4 || c == 5);
            #1;
            $display("image cycle %0d: edge=%b rdy=%b", c, i_edge_valid, i_in_rdy);
            totalCnt++; if (i_edge_valid !== exp) $display("FAIL iedge cyc %0d got %b want %b", c, i_edge_valid, exp); else passCnt++;
            totalCnt++; if (i_in_rdy !== expRdy) $display("FAIL irdy cyc %0d got %b want %b", c, i_in_rdy, expRdy); else passCnt++;
            step();
        end
        i_edge_rdy = '1;
        #1;
        totalCnt++; if (i_edge_valid !== 7'b0000001) $display("FAIL iedge_wrap got %b want 0000001", i_edge_valid); else passCnt++;
        i_in_valid = 1'b0;
        step();
        totalCnt++; if (busy !== 1'b0) $display("FAIL busy_idle got %b want 0", busy); else passCnt++;
    endtask

    task automatic test_blocks3_ext();
        logic [3:0] exp;
        cfg_blocks = 5'd3; cfg_psum_ld = 1'b1; o_in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            o_in_data = 32'd100 + 32'(n);
            exp = 4'b0001 << n;
            #1;
            $display("psum ext %0d: edge=%b data=%0d rdy=%b", n, o_edge_valid, o_edge_data, o_in_rdy);
            totalCnt++; if (o_edge_valid !== exp) $display("FAIL oedge_ext %0d got %b want %b", n, o_edge_valid, exp); else passCnt++;
            totalCnt++; if (o_in_rdy !== 1'b1) $display("FAIL ordy_ext %0d got %b want 1", n, o_in_rdy); else passCnt++;
            totalCnt++; if (o_edge_data !== 32'd100 + 32'(n)) $display("FAIL odata_ext %0d got %0d want %0d", n, o_edge_data, 100 + n); else passCnt++;
            step();
            if (n == 0) begin
                cfg_blocks = 5'd1; cfg_psum_ld = 1'b0;
            end
        end
        for (int n = 0; n < 8; n++) begin
            exp = 4'b0001 << (n % 4);
            #1;
            $display("psum zero %0d: edge=%b data=%0d rdy=%b", n, o_edge_valid, o_edge_data, o_in_rdy);
            totalCnt++; if (o_edge_valid !== exp) $display("FAIL oedge_zero %0d got %b want %b", n, o_edge_valid, exp); else passCnt++;
            totalCnt++; if (o_in_rdy !== 1'b0) $display("FAIL ordy_zero %0d got %b want 0", n, o_in_rdy); else passCnt++;
            totalCnt++; if (o_edge_data !== 32'd0) $display("FAIL odata_zero %0d got %0d want 0", n, o_edge_data); else passCnt++;
            step();
        end
        o_in_valid = 1'b0; cfg_psum_ld = 1'b1;
        #1;
        totalCnt++; if (o_edge_valid !== 4'b0000) $display("FAIL oedge_wait got %b want 0000", o_edge_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b1) $display("FAIL busy_wait got %b want 1", busy); else passCnt++;
        acc_data = {32'd1003, 32'd1002, 32'd1001, 32'd1000};
        acc_valid = 4'b1111; out_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp = 4'b0001 << r;
            #1;
            $display("drain row %0d: data=%0d accrdy=%b", r, out_data, acc_rdy);
            totalCnt++; if (out_data !== 32'd1000 + 32'(r)) $display("FAIL drain_data %0d got %0d want %0d", r, out_data, 1000 + r); else passCnt++;
            totalCnt++; if (acc_rdy !== exp) $display("FAIL drain_accrdy %0d got %b want %b", r, acc_rdy, exp); else passCnt++;
            totalCnt++; if (pass_done !== 1'b0) $display("FAIL drain_pd_early %0d got %b want 0", r, pass_done); else passCnt++;
            step();
        end
        totalCnt++; if (pass_done !== 1'b1) $display("FAIL pd_pulse got %b want 1", pass_done); else passCnt++;
        acc_valid = 4'b0000; out_rdy = 1'b0;
        step();
        totalCnt++; if (pass_done !== 1'b0) $display("FAIL pd_once got %b want 0", pass_done); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL busy_after got %b want 0", busy); else passCnt++;
    endtask

    task automatic test_blocks1_zero();
        logic [3:0] accV [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
        logic       rdyV [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int         rowV [6] = '{0, 1, 1, 1, 2, 3};
        logic [3:0] exp;
        int pdCount = 0;
        cfg_blocks = 5'd0; cfg_psum_ld = 1'b0; o_in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp = 4'b0001 << n;
            #1;
            $display("internal zero %0d: edge=%b rdy=%b", n, o_edge_valid, o_in_rdy);
            totalCnt++; if (o_edge_valid !== exp) $display("FAIL b1_oedge %0d got %b want %b", n, o_edge_valid, exp); else passCnt++;
            totalCnt++; if (o_edge_data !== 32'd0) $display("FAIL b1_odata %0d got %0d want 0", n, o_edge_data); else passCnt++;
            totalCnt++; if (o_in_rdy !== 1'b0) $display("FAIL b1_ordy %0d got %b want 0", n, o_in_rdy); else passCnt++;
            step();
            if (n == 0) cfg_psum_ld = 1'b1;
        end
        #1;
        totalCnt++; if (o_edge_valid !== 4'b0000) $display("FAIL b1_wait got %b want 0000", o_edge_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b1) $display("FAIL b1_busy got %b want 1", busy); else passCnt++;
        acc_data = {32'd2003, 32'd2002, 32'd2001, 32'd2000};
        for (int c = 0; c < 6; c++) begin
            acc_valid = accV[c]; out_rdy = rdyV[c];
            exp = rdyV[c] ? (4'b0001 << rowV[c]) : 4'b0000;
            #1;
            $display("drain cycle %0d: valid=%b data=%0d accrdy=%b", c, out_valid, out_data, acc_rdy);
            totalCnt++; if (out_valid !== (accV[c] != 4'b0000)) $display("FAIL b1_outv %0d got %b want %b", c, out_valid, accV[c] != 4'b0000); else passCnt++;
            totalCnt++; if (acc_rdy !== exp) $display("FAIL b1_accrdy %0d got %b want %b", c, acc_rdy, exp); else passCnt++;
            totalCnt++; if (out_data !== 32'd2000 + 32'(rowV[c])) $display("FAIL b1_data %0d got %0d want %0d", c, out_data, 2000 + rowV[c]); else passCnt++;
            if (pass_done === 1'b1) pdCount++;
            step();
        end
        acc_valid = 4'b0000; out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (pass_done === 1'b1) pdCount++;
            step();
        end
        $display("blocks=0 pass: pass_done pulses=%0d", pdCount);
        totalCnt++; if (pdCount !== 1) $display("FAIL b1_pd_count got %0d want 1", pdCount); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL b1_busy_end got %b want 0", busy); else passCnt++;
    endtask

    initial begin
        aclr = 1'b0; cfg_blocks = 5'd1; cfg_psum_ld = 1'b1;
        k_in_valid = 1'b0; k_edge_rdy = '1;
        i_in_valid = 1'b0; i_edge_rdy = '1;
        o_in_valid = 1'b0; o_in_data = '0; o_edge_rdy = '1;
        acc_valid = '0; acc_data = '0; out_rdy = 1'b0;
        step(); step();
        test_reset();
        test_kernel();
        test_image();
        test_blocks3_ext();
        test_blocks1_zero();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
